hyperram_responder: RTL and testbench



---
 rtl/hyperram_responder.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_hyperram_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_responder.sv
// HyperBus device-side responder: oversamples the controller's pad signals with clk_i and serves
// memory-space bursts from an internal word array. Define HYPERRAM_RESP_REGSPACE_EN for CR0/ID0 register space.
module hyperram_responder #(
  parameter int unsigned MemWords    = 1024,
  parameter int unsigned LatencyClks = 6,
  parameter logic [15:0] Cr0Reset    = 16'h8F1F
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hyper_reset_ni,
  input  logic       hyper_cs_ni,
  input  logic       hyper_ck_i,
  input  logic [7:0] hyper_dq_i,
  output logic [7:0] hyper_dq_o,
  output logic       hyper_dq_oe_o,
  input  logic       hyper_rwds_i,
  output logic       hyper_rwds_o,
  output logic       hyper_rwds_oe_o
);

  localparam int unsigned AW = $clog2(MemWords);
  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [AW-1:0] GRP_MASK = AW'(15);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CA    = 3'd1;
  localparam logic [2:0] S_LAT   = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic          ck_s1_q, ck_s2_q, ck_s3_q, cs_s1_q, cs_s2_q, rwds_s1_q, rwds_s2_q;
  logic [7:0]    dq_s1_q, dq_s2_q;
  logic          ck_rise, ck_fall;

  logic [2:0]    state_q, state_d, cnt_q, cnt_d;
  logic [39:0]   ca_q, ca_d;
  logic          rd_q, rd_d, reg_q, reg_d, lin_q, lin_d, half_q, half_d;
  logic [AW-1:0] addr_q, addr_d, addr_inc;
  logic [7:0]    whi_q, whi_d;
  logic          wmhi_q, wmhi_d;
  logic          pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [7:0]    dq_q, dq_d;
  logic          dq_oe_q, dq_oe_d, rwds_q, rwds_d, rwds_oe_q, rwds_oe_d;
  logic          we_hi, we_lo, rd_issue;
  logic [31:0]   ca_waddr;
  logic [15:0]   reg_rdata, rd_word_q;
  logic [15:0]   mem_q [MemWords];
`ifdef HYPERRAM_RESP_REGSPACE_EN
  logic [15:0]   cr0_q, cr0_d;
  logic [1:0]    regsel_q, regsel_d;  // [1] CR0, [0] ID0
`endif

  // Two-flop synchronizers; the third CK flop feeds edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ck_s1_q   <= 1'b0;
      ck_s2_q   <= 1'b0;
      ck_s3_q   <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      dq_s1_q   <= 8'h00;
      dq_s2_q   <= 8'h00;
      rwds_s1_q <= 1'b0;
      rwds_s2_q <= 1'b0;
    end else begin
      ck_s1_q   <= hyper_ck_i;
      ck_s2_q   <= ck_s1_q;
      ck_s3_q   <= ck_s2_q;
      cs_s1_q   <= hyper_cs_ni;
      cs_s2_q   <= cs_s1_q;
      dq_s1_q   <= hyper_dq_i;
      dq_s2_q   <= dq_s1_q;
      rwds_s1_q <= hyper_rwds_i;
      rwds_s2_q <= rwds_s1_q;
    end
  end

  assign ck_rise  = ck_s2_q & ~ck_s3_q;
  assign ck_fall  = ~ck_s2_q & ck_s3_q;
  // Full word address as it stands when the sixth CA byte is on dq_s2_q.
  assign ca_waddr = {ca_q[36:8], dq_s2_q[2:0]};
  assign addr_inc = lin_q ? addr_q + ONE
                          : (addr_q & ~GRP_MASK) | ((addr_q + ONE) & GRP_MASK);

`ifdef HYPERRAM_RESP_REGSPACE_EN
  assign reg_rdata = regsel_q[1] ? cr0_q : (regsel_q[0] ? 16'h0C81 : 16'h0000);
`else
  assign reg_rdata = 16'h0000;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ca_d      = ca_q;
    rd_d      = rd_q;
    reg_d     = reg_q;
    lin_d     = lin_q;
    half_d    = half_q;
    addr_d    = addr_q;
    whi_d     = whi_q;
    wmhi_d    = wmhi_q;
    pend_hi_d = 1'b0;
    pend_lo_d = 1'b0;
    we_hi     = 1'b0;
    we_lo     = 1'b0;
    rd_issue  = 1'b0;
    dq_d      = dq_q;
    dq_oe_d   = dq_oe_q;
    rwds_d    = rwds_q;
    rwds_oe_d = rwds_oe_q;
`ifdef HYPERRAM_RESP_REGSPACE_EN
    cr0_d     = cr0_q;
    regsel_d  = regsel_q;
`endif

    // Read bytes launch one cycle after the array read, so DQ and RWDS move together.
    if (pend_hi_q) begin
      dq_d      = rd_word_q[15:8];
      rwds_d    = 1'b1;
      dq_oe_d   = 1'b1;
      rwds_oe_d = 1'b1;
    end
    if (pend_lo_q) begin
      dq_d   = rd_word_q[7:0];
      rwds_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!cs_s2_q) begin
          state_d   = S_CA;
          cnt_d     = 3'd0;
          half_d    = 1'b0;
          rwds_d    = 1'b0;
          rwds_oe_d = 1'b1;
        end
      end
      S_CA: begin
        if (ck_rise || ck_fall) begin
          ca_d  = {ca_q[31:0], dq_s2_q};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            rd_d      = ca_q[39];
            reg_d     = ca_q[38];
            lin_d     = ca_q[37];
            addr_d    = AW'(ca_waddr % MemWords);
            rwds_oe_d = 1'b0;
`ifdef HYPERRAM_RESP_REGSPACE_EN
            regsel_d  = {ca_waddr == 32'h0000_1000, ca_waddr == 32'h0000_0000};
`endif
            if (ca_q[39] || !ca_q[38]) begin
              state_d = S_LAT;
              cnt_d   = 3'(LatencyClks);
            end else begin
`ifdef HYPERRAM_RESP_REGSPACE_EN
              state_d = S_WDATA;  // register writes carry no latency
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
      S_LAT: begin
        if (ck_rise) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = rd_q ? S_RDATA : S_WDATA;
        end
      end
      S_WDATA: begin
        if (ck_rise) begin
          whi_d  = dq_s2_q;
          wmhi_d = rwds_s2_q & ~reg_q;
          half_d = 1'b1;
        end else if (ck_fall && half_q) begin
          half_d = 1'b0;
          if (reg_q) begin
`ifdef HYPERRAM_RESP_REGSPACE_EN
            if (regsel_q[1]) cr0_d = {whi_q, dq_s2_q};
`endif
            state_d = S_DONE;
          end else begin
            we_hi  = ~wmhi_q;
            we_lo  = ~rwds_s2_q;
            addr_d = addr_inc;
          end
        end
      end
      S_RDATA: begin
        if (ck_rise) begin
          rd_issue  = 1'b1;
          pend_hi_d = 1'b1;
          half_d    = 1'b1;
        end else if (ck_fall && half_q) begin
          pend_lo_d = 1'b1;
          half_d    = 1'b0;
          addr_d    = addr_inc;
        end
      end
      S_DONE:  ;
      default: state_d = S_IDLE;
    endcase

    // CS# high aborts everything, including a half-received write word.
    if (cs_s2_q || !hyper_reset_ni) begin
      state_d   = S_IDLE;
      dq_oe_d   = 1'b0;
      rwds_oe_d = 1'b0;
      pend_hi_d = 1'b0;
      pend_lo_d = 1'b0;
      half_d    = 1'b0;
      we_hi     = 1'b0;
      we_lo     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      ca_q      <= 40'd0;
      rd_q      <= 1'b0;
      reg_q     <= 1'b0;
      lin_q     <= 1'b0;
      half_q    <= 1'b0;
      addr_q    <= '0;
      whi_q     <= 8'h00;
      wmhi_q    <= 1'b0;
      pend_hi_q <= 1'b0;
      pend_lo_q <= 1'b0;
      dq_q      <= 8'h00;
      dq_oe_q   <= 1'b0;
      rwds_q    <= 1'b0;
      rwds_oe_q <= 1'b0;
`ifdef HYPERRAM_RESP_REGSPACE_EN
      cr0_q     <= Cr0Reset;
      regsel_q  <= 2'b00;
`endif
    end else if (!hyper_reset_ni) begin
      state_q   <= S_IDLE;
      half_q    <= 1'b0;
      pend_hi_q <= 1'b0;
      pend_lo_q <= 1'b0;
      dq_q      <= 8'h00;
      dq_oe_q   <= 1'b0;
      rwds_q    <= 1'b0;
      rwds_oe_q <= 1'b0;
`ifdef HYPERRAM_RESP_REGSPACE_EN
      cr0_q     <= Cr0Reset;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ca_q      <= ca_d;
      rd_q      <= rd_d;
      reg_q     <= reg_d;
      lin_q     <= lin_d;
      half_q    <= half_d;
      addr_q    <= addr_d;
      whi_q     <= whi_d;
      wmhi_q    <= wmhi_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      dq_q      <= dq_d;
      dq_oe_q   <= dq_oe_d;
      rwds_q    <= rwds_d;
      rwds_oe_q <= rwds_oe_d;
`ifdef HYPERRAM_RESP_REGSPACE_EN
      cr0_q     <= cr0_d;
      regsel_q  <= regsel_d;
`endif
    end
  end

  // Storage is never reset; byte lanes are written independently for RWDS masking.
  always_ff @(posedge clk_i) begin
    if (we_hi) mem_q[addr_q][15:8] <= whi_q;
    if (we_lo) mem_q[addr_q][7:0]  <= dq_s2_q;
    if (rd_issue) rd_word_q <= reg_q ? reg_rdata : mem_q[addr_q];
  end

  assign hyper_dq_o      = dq_q;
  assign hyper_dq_oe_o   = dq_oe_q;
  assign hyper_rwds_o    = rwds_q;
  assign hyper_rwds_oe_o = rwds_oe_q;

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed bench for hyperram_responder: drives HyperBus transactions and checks captured read bursts.
module tb_hyperram_responder;
  localparam int LAT = 6;
`ifdef HYPERRAM_RESP_REGSPACE_EN
  localparam logic [15:0] EXP_ID0   = 16'h0C81;
  localparam logic [15:0] EXP_CR0W  = 16'h8F0F;
  localparam logic [15:0] EXP_CR0RS = 16'h8F1F;
`else
  localparam logic [15:0] EXP_ID0   = 16'h0000;
  localparam logic [15:0] EXP_CR0W  = 16'h0000;
  localparam logic [15:0] EXP_CR0RS = 16'h0000;
`endif

  logic       clk = 1'b0;
  logic       rst_n, hrst_n, cs_n, ck, rwds_i;
  logic [7:0] dq_i, dq_o;
  logic       dq_oe, rwds_o, rwds_oe;
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [15:0] wbuf [16];
  logic [1:0]  wmask [16];
  logic [8:0]  cap_q [$];
  logic        prev_oe = 1'b0;
  logic        prev_rwds = 1'b0;
  logic [1:0]  ca_rwds;

  always #5 clk = ~clk;

  hyperram_responder #(.MemWords(1024), .LatencyClks(LAT), .Cr0Reset(16'h8F1F)) dut (
    .clk_i(clk), .rst_ni(rst_n), .hyper_reset_ni(hrst_n), .hyper_cs_ni(cs_n),
    .hyper_ck_i(ck), .hyper_dq_i(dq_i), .hyper_dq_o(dq_o), .hyper_dq_oe_o(dq_oe),
    .hyper_rwds_i(rwds_i), .hyper_rwds_o(rwds_o), .hyper_rwds_oe_o(rwds_oe)
  );

  // Record each read byte as {rwds, dq} whenever RWDS changes while the bus is driven.
  always @(negedge clk) begin
    if (dq_oe && rwds_oe && (!prev_oe || rwds_o != prev_rwds)) cap_q.push_back({rwds_o, dq_o});
    prev_oe   <= dq_oe && rwds_oe;
    prev_rwds <= rwds_o;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic half(input logic [7:0] b, input logic m);
    @(negedge clk);
    dq_i = b;
    rwds_i = m;
    repeat (2) @(negedge clk);
    ck = ~ck;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_ca(input logic rd, input logic rs, input logic lin, input logic [31:0] a,
                         output logic [1:0] rw);
    logic [47:0] ca;
    ca = {rd, rs, lin, a[31:3], 13'd0, a[2:0]};
    rw = 2'b00;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      half(ca[47-8*i -: 8], 1'b0);
      if (i == 2) rw = {rwds_oe, rwds_o};
    end
  endtask

  task automatic lat_cycles();
    for (int i = 0; i < LAT; i++) begin
      half(8'h00, 1'b0);
      half(8'h00, 1'b0);
    end
  endtask

  task automatic end_cs();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    if (ck) ck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic write_mem(input logic lin, input logic [31:0] a, input int n);
    send_ca(1'b0, 1'b0, lin, a, ca_rwds);
    lat_cycles();
    for (int i = 0; i < n; i++) begin
      half(wbuf[i][15:8], wmask[i][1]);
      half(wbuf[i][7:0], wmask[i][0]);
    end
    end_cs();
  endtask

  task automatic read_xfer(input logic rs, input logic lin, input logic [31:0] a, input int n);
    cap_q.delete();
    send_ca(1'b1, rs, lin, a, ca_rwds);
    lat_cycles();
    for (int i = 0; i < n; i++) begin
      half(8'h00, 1'b0);
      half(8'h00, 1'b0);
    end
    repeat (4) @(negedge clk);
    end_cs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hrst_n = 1'b1; cs_n = 1'b1; ck = 1'b0; dq_i = 8'h00; rwds_i = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (dq_o !== 8'h00) begin tests_failed++; $display("FAIL reset_dq: got %h want 00", dq_o); end
    tests_run++;
    if (dq_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_dq_oe: got %b want 0", dq_oe); end
    tests_run++;
    if (rwds_o !== 1'b0) begin tests_failed++; $display("FAIL reset_rwds: got %b want 0", rwds_o); end
    tests_run++;
    if (rwds_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_rwds_oe: got %b want 0", rwds_oe); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_linear();
    logic [15:0] exp_w [4];
    logic [8:0]  g_hi, g_lo;
    exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin wbuf[i] = exp_w[i]; wmask[i] = 2'b00; end
    write_mem(1'b1, 32'h10, 4);
    tests_run++;
    if (ca_rwds !== 2'b10) begin tests_failed++; $display("FAIL ca_rwds: got oe/val %b want 10", ca_rwds); end
    read_xfer(1'b0, 1'b1, 32'h10, 4);
    tests_run++;
    if (cap_q.size() != 8) begin tests_failed++; $display("FAIL lin_count: got %0d want 8", cap_q.size()); end
    for (int i = 0; i < 4; i++) begin
      g_hi = 'x; g_lo = 'x;
      if (cap_q.size() > 2*i+1) begin g_hi = cap_q[2*i]; g_lo = cap_q[2*i+1]; end
      tests_run++;
      if ({g_hi, g_lo} !== {1'b1, exp_w[i][15:8], 1'b0, exp_w[i][7:0]}) begin
        tests_failed++;
        $display("FAIL lin_word%0d: got %h/%h want rwds1 %h rwds0 %h", i, g_hi, g_lo, exp_w[i][15:8], exp_w[i][7:0]);
      end
    end
  endtask

  task automatic test_masked();
    logic [8:0] g_hi, g_lo;
    wbuf[0] = 16'h5566; wmask[0] = 2'b00;
    write_mem(1'b1, 32'h20, 1);
    wbuf[0] = 16'hABCD; wmask[0] = 2'b10;
    write_mem(1'b1, 32'h20, 1);
    read_xfer(1'b0, 1'b1, 32'h20, 1);
    tests_run++;
    if (cap_q.size() != 2) begin tests_failed++; $display("FAIL mask_count: got %0d want 2", cap_q.size()); end
    g_hi = 'x; g_lo = 'x;
    if (cap_q.size() > 1) begin g_hi = cap_q[0]; g_lo = cap_q[1]; end
    tests_run++;
    if ({g_hi[7:0], g_lo[7:0]} !== 16'h55CD) begin
      tests_failed++; $display("FAIL mask_word: got %h%h want 55cd", g_hi[7:0], g_lo[7:0]);
    end
  endtask

  task automatic test_wrapped();
    logic [15:0] exp_w [4];
    logic [8:0]  g_hi, g_lo;
    exp_w = '{16'hE1E1, 16'hF1F1, 16'h1111, 16'h2222};
    wbuf[0] = 16'hE1E1; wbuf[1] = 16'hF1F1; wmask[0] = 2'b00; wmask[1] = 2'b00;
    write_mem(1'b1, 32'h1E, 2);
    read_xfer(1'b0, 1'b0, 32'h1E, 4);
    tests_run++;
    if (cap_q.size() != 8) begin tests_failed++; $display("FAIL wrap_count: got %0d want 8", cap_q.size()); end
    for (int i = 0; i < 4; i++) begin
      g_hi = 'x; g_lo = 'x;
      if (cap_q.size() > 2*i+1) begin g_hi = cap_q[2*i]; g_lo = cap_q[2*i+1]; end
      tests_run++;
      if ({g_hi, g_lo} !== {1'b1, exp_w[i][15:8], 1'b0, exp_w[i][7:0]}) begin
        tests_failed++;
        $display("FAIL wrap_word%0d: got %h/%h want %h", i, g_hi, g_lo, exp_w[i]);
      end
    end
  endtask

  task automatic test_cs_abort();
    logic [8:0] g_hi, g_lo;
    wbuf[0] = 16'h3030; wmask[0] = 2'b00;
    write_mem(1'b1, 32'h30, 1);
    send_ca(1'b0, 1'b0, 1'b1, 32'h30, ca_rwds);
    for (int i = 0; i < 4; i++) half(8'h00, 1'b0);
    end_cs();
    send_ca(1'b0, 1'b0, 1'b1, 32'h30, ca_rwds);
    lat_cycles();
    half(8'hAA, 1'b0);
    end_cs();
    send_ca(1'b1, 1'b0, 1'b1, 32'h30, ca_rwds);
    lat_cycles();
    half(8'h00, 1'b0);
    half(8'h00, 1'b0);
    tests_run++;
    if (dq_oe !== 1'b1) begin tests_failed++; $display("FAIL abort_rd_oe_on: got %b want 1", dq_oe); end
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({dq_oe, rwds_oe} !== 2'b00) begin
      tests_failed++; $display("FAIL abort_oe_off: got %b want 00", {dq_oe, rwds_oe});
    end
    end_cs();
    read_xfer(1'b0, 1'b1, 32'h30, 1);
    g_hi = 'x; g_lo = 'x;
    if (cap_q.size() > 1) begin g_hi = cap_q[0]; g_lo = cap_q[1]; end
    tests_run++;
    if ({g_hi, g_lo} !== {1'b1, 8'h30, 1'b0, 8'h30}) begin
      tests_failed++; $display("FAIL abort_word: got %h/%h want 3030", g_hi, g_lo);
    end
  endtask

  task automatic test_regspace();
    logic [8:0] g_hi, g_lo;
    send_ca(1'b0, 1'b1, 1'b1, 32'h1000, ca_rwds);
    half(8'h8F, 1'b0);
    half(8'h0F, 1'b0);
    end_cs();
    read_xfer(1'b1, 1'b1, 32'h0, 1);
    g_hi = 'x; g_lo = 'x;
    if (cap_q.size() > 1) begin g_hi = cap_q[0]; g_lo = cap_q[1]; end
    tests_run++;
    if ({g_hi, g_lo} !== {1'b1, EXP_ID0[15:8], 1'b0, EXP_ID0[7:0]}) begin
      tests_failed++; $display("FAIL reg_id0: got %h/%h want %h", g_hi, g_lo, EXP_ID0);
    end
    read_xfer(1'b1, 1'b1, 32'h1000, 1);
    g_hi = 'x; g_lo = 'x;
    if (cap_q.size() > 1) begin g_hi = cap_q[0]; g_lo = cap_q[1]; end
    tests_run++;
    if ({g_hi, g_lo} !== {1'b1, EXP_CR0W[15:8], 1'b0, EXP_CR0W[7:0]}) begin
      tests_failed++; $display("FAIL reg_cr0_wr: got %h/%h want %h", g_hi, g_lo, EXP_CR0W);
    end
  endtask

  task automatic test_hyper_reset();
    logic [8:0] g_hi, g_lo;
    send_ca(1'b1, 1'b0, 1'b1, 32'h10, ca_rwds);
    lat_cycles();
    half(8'h00, 1'b0);
    half(8'h00, 1'b0);
    @(negedge clk);
    hrst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({dq_oe, rwds_oe, rwds_o, dq_o} !== 11'd0) begin
      tests_failed++; $display("FAIL hrst_outputs: got %b want all zero", {dq_oe, rwds_oe, rwds_o, dq_o});
    end
    hrst_n = 1'b1;
    end_cs();
    read_xfer(1'b1, 1'b1, 32'h1000, 1);
    g_hi = 'x; g_lo = 'x;
    if (cap_q.size() > 1) begin g_hi = cap_q[0]; g_lo = cap_q[1]; end
    tests_run++;
    if ({g_hi, g_lo} !== {1'b1, EXP_CR0RS[15:8], 1'b0, EXP_CR0RS[7:0]}) begin
      tests_failed++; $display("FAIL hrst_cr0: got %h/%h want %h", g_hi, g_lo, EXP_CR0RS);
    end
    read_xfer(1'b0, 1'b1, 32'h11, 1);
    g_hi = 'x; g_lo = 'x;
    if (cap_q.size() > 1) begin g_hi = cap_q[0]; g_lo = cap_q[1]; end
    tests_run++;
    if ({g_hi, g_lo} !== {1'b1, 8'h22, 1'b0, 8'h22}) begin
      tests_failed++; $display("FAIL hrst_mem_kept: got %h/%h want 2222", g_hi, g_lo);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_masked();
    test_wrapped();
    test_cs_abort();
    test_regspace();
    test_hyper_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
